// File: rtl/mix_in_buffer_if.sv
// mix_in_buffer_if: load-stream and mix_layer handshake bundle for mix_in_buffer.
// master = upstream producer / layer side, slave = the buffer itself.
interface mix_in_buffer_if #(
    parameter int BIT_LENGTH = 16,
    parameter int HID_LENGTH = 24,
    parameter int DATA_N     = 6,
    parameter int STATE_LEN  = 4
);
    logic [STATE_LEN-1:0]                        state_in;
    logic                                        load_valid;
    logic                                        load_ready;
    logic [DATA_N*BIT_LENGTH-1:0]                load_data;
    logic                                        run;
    logic                                        valid;
    logic [STATE_LEN-1:0]                        state_out;
    logic [HID_LENGTH*HID_LENGTH*BIT_LENGTH-1:0] data_out;
    logic [6:0]                                  word_cnt;
    logic                                        done;

    modport master (
        output state_in, load_valid, load_data, valid,
        input  load_ready, run, state_out, data_out, word_cnt, done
    );

    modport slave (
        input  state_in, load_valid, load_data, valid,
        output load_ready, run, state_out, data_out, word_cnt, done
    );
endinterface

// File: rtl/mix_in_buffer.sv
// mix_in_buffer: assembles a HID_LENGTH x HID_LENGTH matrix from DATA_N-element
// load words, then holds it stable and requests a mix_layer run until valid.
// Optional build macro: MIX_IN_BUF_TRANSPOSE_EN stores the matrix transposed.
module mix_in_buffer #(
    parameter int BIT_LENGTH = 16,
    parameter int HID_LENGTH = 24,
    parameter int DATA_N     = 6,
    parameter int STATE_LEN  = 4
) (
    input  logic            clk,
    input  logic            rst,
    mix_in_buffer_if.slave  bus
);
    localparam int ELEMS = HID_LENGTH * HID_LENGTH;
    localparam int WORDS = ELEMS / DATA_N;
    localparam int IDX_W = $clog2(ELEMS);
    localparam logic [6:0]       LAST_WORD = 7'(WORDS - 1);
    localparam logic [IDX_W-1:0] HID_W     = IDX_W'(HID_LENGTH);
    localparam logic [IDX_W-1:0] DATA_N_W  = IDX_W'(DATA_N);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                        state_r;
    state_t                        state_s;
    logic [6:0]                    word_cnt_r;
    logic [ELEMS*BIT_LENGTH-1:0]   data_r;
    logic [STATE_LEN-1:0]          state_out_r;
    logic                          run_r;
    logic                          done_r;
    logic                          accept_s;
    logic                          last_s;
    logic                          finish_s;
    logic [IDX_W-1:0]              elem_s [DATA_N];
    logic [IDX_W-1:0]              pos_s  [DATA_N];

    assign accept_s = bus.load_valid && (state_r == ST_LOAD);
    assign last_s   = (word_cnt_r == LAST_WORD);
    // valid only completes a run once the FSM is already in RUN, so a valid
    // coinciding with the final word is not consumed
    assign finish_s = bus.valid && (state_r == ST_RUN);

    // Next-state decode of the load/run FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && last_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (bus.valid) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Destination element position for each lane of the current word
    always_comb begin
        for (int k = 0; k < DATA_N; k++) begin
            elem_s[k] = DATA_N_W * IDX_W'(word_cnt_r) + IDX_W'(k);
`ifdef MIX_IN_BUF_TRANSPOSE_EN
            pos_s[k] = (elem_s[k] % HID_W) * HID_W + (elem_s[k] / HID_W);
`else
            pos_s[k] = elem_s[k];
`endif
        end
    end

    // Matrix storage, word counter and captured layer state
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r      <= '0;
            word_cnt_r  <= 7'd0;
            state_out_r <= '0;
        end else if (accept_s) begin
            for (int k = 0; k < DATA_N; k++) begin
                data_r[int'(pos_s[k])*BIT_LENGTH +: BIT_LENGTH] <=
                    bus.load_data[k*BIT_LENGTH +: BIT_LENGTH];
            end
            if (word_cnt_r == 7'd0) begin
                state_out_r <= bus.state_in;
            end
            if (last_s) begin
                word_cnt_r <= 7'd0;
            end else begin
                word_cnt_r <= word_cnt_r + 7'd1;
            end
        end
    end

    // run request and one-cycle completion pulse toward/from mix_layer
    always_ff @(posedge clk) begin
        if (rst) begin
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= finish_s;
            if (finish_s) begin
                run_r <= 1'b0;
            end else if (accept_s && last_s) begin
                run_r <= 1'b1;
            end
        end
    end

    assign bus.load_ready = (state_r == ST_LOAD);
    assign bus.run        = run_r;
    assign bus.done       = done_r;
    assign bus.word_cnt   = word_cnt_r;
    assign bus.state_out  = state_out_r;
    assign bus.data_out   = data_r;
endmodule

// File: tb/tb_mix_in_buffer.sv
// tb_mix_in_buffer: directed self-checking bench for mix_in_buffer.
module tb_mix_in_buffer;
    localparam int B     = 16;
    localparam int H     = 24;
    localparam int N     = 6;
    localparam int S     = 4;
    localparam int EL    = H * H;
    localparam int WORDS = EL / N;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   first_bad;
    logic [EL*B-1:0] exp_v;

    mix_in_buffer_if #(.BIT_LENGTH(B), .HID_LENGTH(H), .DATA_N(N), .STATE_LEN(S)) bus ();

    mix_in_buffer #(.BIT_LENGTH(B), .HID_LENGTH(H), .DATA_N(N), .STATE_LEN(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // storage position of linear element e
    function automatic int pos_of(input int e);
`ifdef MIX_IN_BUF_TRANSPOSE_EN
        return (e % H) * H + e / H;
`else
        return e;
`endif
    endfunction

    // element value for the data patterns: 0 index, 1 all ones, 2 index^A5A5
    function automatic logic [B-1:0] val_of(input int e, input int mode);
        logic [B-1:0] v;
        v = 16'(e);
        if (mode == 1) v = 16'hFFFF;
        else if (mode == 2) v = v ^ 16'hA5A5;
        return v;
    endfunction

    function automatic logic [N*B-1:0] word_of(input int w, input int mode);
        logic [N*B-1:0] d;
        for (int k = 0; k < N; k++) d[k*B +: B] = val_of(N*w + k, mode);
        return d;
    endfunction

    task automatic build_exp(input int mode);
        for (int e = 0; e < EL; e++) exp_v[pos_of(e)*B +: B] = val_of(e, mode);
    endtask

    // number of elements of act differing from exp_v; first index in first_bad
    function automatic int count_bad(input logic [EL*B-1:0] act);
        int c;
        c = 0;
        first_bad = -1;
        for (int i = 0; i < EL; i++) begin
            if (act[i*B +: B] !== exp_v[i*B +: B]) begin
                if (c == 0) first_bad = i;
                c++;
            end
        end
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.valid = 1'b0;
        bus.state_in = 4'd0;
        bus.load_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); end
        n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b want 0", bus.run); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.word_cnt !== 7'd0) begin n_err++; $display("FAIL reset_word_cnt: got %0d want 0", bus.word_cnt); end
        n_cmp++; if (bus.state_out !== 4'd0) begin n_err++; $display("FAIL reset_state_out: got %0d want 0", bus.state_out); end
        n_cmp++; if (bus.data_out !== '0) begin n_err++; $display("FAIL reset_data_out: nonzero data"); end
    endtask

    // index-valued frame; state_in only equals 3 on word 0
    task automatic test_index_frame();
        int bad;
        for (int w = 0; w < WORDS; w++) begin
            @(negedge clk);
            if (w == WORDS - 1) begin
                n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL run_before_last: got %b want 0", bus.run); end
                n_cmp++; if (bus.word_cnt !== 7'd95) begin n_err++; $display("FAIL cnt_before_last: got %0d want 95", bus.word_cnt); end
            end
            bus.load_valid = 1'b1;
            bus.load_data = word_of(w, 0);
            bus.state_in = (w == 0) ? 4'b0011 : 4'b1111;
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        build_exp(0);
        n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL run_after_frame: got %b want 1", bus.run); end
        n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL ready_in_run: got %b want 0", bus.load_ready); end
        n_cmp++; if (bus.state_out !== 4'd3) begin n_err++; $display("FAIL state_out_frame1: got %0d want 3", bus.state_out); end
        n_cmp++; if (bus.word_cnt !== 7'd0) begin n_err++; $display("FAIL cnt_after_frame: got %0d want 0", bus.word_cnt); end
        bad = count_bad(bus.data_out);
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL index_data: %0d bad, elem %0d got %h want %h", bad, first_bad, bus.data_out[first_bad*B +: B], exp_v[first_bad*B +: B]); end
`ifdef MIX_IN_BUF_TRANSPOSE_EN
        n_cmp++; if (bus.data_out[1*B +: B] !== 16'd24) begin n_err++; $display("FAIL transpose_pos1: got %0d want 24", bus.data_out[1*B +: B]); end
`endif
    endtask

    // load_valid held in RUN is refused; valid ends the run with a done pulse
    task automatic test_run_hold();
        int bad;
        repeat (100) begin
            @(negedge clk);
            bus.load_valid = 1'b1;
            bus.load_data = {N{16'hDEAD}};
        end
        @(negedge clk);
        n_cmp++; if (bus.word_cnt !== 7'd0) begin n_err++; $display("FAIL hold_cnt: got %0d want 0", bus.word_cnt); end
        n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL hold_run: got %b want 1", bus.run); end
        bad = count_bad(bus.data_out);
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_data: %0d bad, elem %0d got %h want %h", bad, first_bad, bus.data_out[first_bad*B +: B], exp_v[first_bad*B +: B]); end
        bus.load_valid = 1'b0;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL valid_run: got %b want 0", bus.run); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL valid_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL valid_ready: got %b want 1", bus.load_ready); end
    endtask

    // new frame starts in the done cycle, then rst after 40 words, then a full all-ones frame
    task automatic test_restart_and_reset();
        int bad;
        bus.load_valid = 1'b1;
        bus.load_data = word_of(0, 1);
        bus.state_in = 4'b0100;
        @(negedge clk);
        n_cmp++; if (bus.word_cnt !== 7'd1) begin n_err++; $display("FAIL restart_cnt: got %0d want 1", bus.word_cnt); end
        n_cmp++; if (bus.state_out !== 4'd4) begin n_err++; $display("FAIL restart_state: got %0d want 4", bus.state_out); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
        bus.state_in = 4'b1001;
        for (int w = 1; w < 40; w++) begin
            bus.load_data = word_of(w, 1);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        n_cmp++; if (bus.word_cnt !== 7'd40) begin n_err++; $display("FAIL cnt_40: got %0d want 40", bus.word_cnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.word_cnt !== 7'd0) begin n_err++; $display("FAIL midframe_rst_cnt: got %0d want 0", bus.word_cnt); end
        n_cmp++; if (bus.data_out !== '0) begin n_err++; $display("FAIL midframe_rst_data: nonzero data"); end
        n_cmp++; if (bus.state_out !== 4'd0) begin n_err++; $display("FAIL midframe_rst_state: got %0d want 0", bus.state_out); end
        for (int w = 0; w < WORDS; w++) begin
            if (w == WORDS - 1) begin
                n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL ones_run_early: got %b want 0", bus.run); end
                n_cmp++; if (bus.word_cnt !== 7'd95) begin n_err++; $display("FAIL ones_cnt_95: got %0d want 95", bus.word_cnt); end
            end
            bus.load_valid = 1'b1;
            bus.load_data = word_of(w, 1);
            bus.state_in = (w == 0) ? 4'b0111 : 4'b0001;
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        build_exp(1);
        n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL ones_run: got %b want 1", bus.run); end
        n_cmp++; if (bus.state_out !== 4'd7) begin n_err++; $display("FAIL ones_state: got %0d want 7", bus.state_out); end
        bad = count_bad(bus.data_out);
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ones_data: %0d bad, elem %0d got %h want ffff", bad, first_bad, bus.data_out[first_bad*B +: B]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL run_rst_run: got %b want 0", bus.run); end
        n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL run_rst_ready: got %b want 1", bus.load_ready); end
        n_cmp++; if (bus.data_out !== '0) begin n_err++; $display("FAIL run_rst_data: nonzero data"); end
    endtask

    // load_valid gaps with valid toggling in LOAD; last word coincides with valid
    task automatic test_gaps();
        int w;
        int cyc;
        int bad;
        logic lv;
        w = 0;
        cyc = 0;
        while (w < WORDS) begin
            n_cmp++; if (bus.word_cnt !== 7'(w)) begin n_err++; $display("FAIL gap_cnt c%0d: got %0d want %0d", cyc, bus.word_cnt, w); end
            n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL gap_done c%0d: got %b want 0", cyc, bus.done); end
            lv = (w == WORDS - 1) ? 1'b1 : ((cyc % 3) != 1);
            bus.load_valid = lv;
            bus.valid = (w == WORDS - 1) ? 1'b1 : ((cyc % 2) == 0);
            bus.load_data = word_of(w, 2);
            @(negedge clk);
            if (lv) w++;
            cyc++;
        end
        bus.load_valid = 1'b0;
        bus.valid = 1'b0;
        build_exp(2);
        n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL gap_run: got %b want 1", bus.run); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL gap_same_edge_done: got %b want 0", bus.done); end
        bad = count_bad(bus.data_out);
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL gap_data: %0d bad, elem %0d got %h want %h", bad, first_bad, bus.data_out[first_bad*B +: B], exp_v[first_bad*B +: B]); end
        @(negedge clk);
        n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL gap_still_run: got %b want 1", bus.run); end
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL gap_done_pulse: got %b want 1", bus.done); end
        n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL gap_run_clear: got %b want 0", bus.run); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL gap_done_single: got %b want 0", bus.done); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_index_frame();
        test_run_hold();
        test_restart_and_reset();
        test_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
